// File: rtl/exp_prod_sched_if.sv
// Handshake and operand bundle between the product scheduler and its producer/consumer.
// Operands and result are unsigned fixed-point words, 26 bits wide.
interface exp_prod_sched_if;
  logic        mul_valid;
  logic [25:0] multiplier_0;
  logic [25:0] multiplier_1;
  logic [25:0] multiplier_2;
  logic [25:0] multiplier_3;
  logic [25:0] multiplier_4;
  logic [25:0] multiplier_5;
  logic        busy;
  logic [25:0] result;
  logic        ovf;
  logic        res_valid;
  logic        res_ready;
  logic        drop;

  modport master (
    output mul_valid,
    output multiplier_0, multiplier_1, multiplier_2,
    output multiplier_3, multiplier_4, multiplier_5,
    output res_ready,
    input  busy, result, ovf, res_valid, drop
  );

  modport slave (
    input  mul_valid,
    input  multiplier_0, multiplier_1, multiplier_2,
    input  multiplier_3, multiplier_4, multiplier_5,
    input  res_ready,
    output busy, result, ovf, res_valid, drop
  );
endinterface

// File: rtl/exp_prod_sched.sv
// Sequential fixed-point product of six captured operands, one multiply per cycle,
// with saturation tracking and a valid/ready result handshake.
module exp_prod_sched #(
  parameter int FRAC_W = 11
) (
  input logic              clk,
  input logic              rst_n,
  exp_prod_sched_if.slave  bus
);

  localparam int OP_W   = 26;
  localparam int PROD_W = 2 * OP_W;
  localparam int N_OPS  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [OP_W-1:0]   op_in  [N_OPS];
  logic [OP_W-1:0]   op_reg [N_OPS];
  logic [2:0]        cnt_reg;
  logic [OP_W-1:0]   acc_reg;
  logic [OP_W-1:0]   result_reg;
  logic              ovf_reg;
  logic              drop_reg;
  logic [OP_W-1:0]   cur_op;
  logic [PROD_W-1:0] product;
  logic              sat_hit;
  logic [OP_W-1:0]   acc_step;
  logic              sat_step;
  logic              busy_c;
  logic              res_valid_c;

  assign op_in[0] = bus.multiplier_0;
  assign op_in[1] = bus.multiplier_1;
  assign op_in[2] = bus.multiplier_2;
  assign op_in[3] = bus.multiplier_3;
  assign op_in[4] = bus.multiplier_4;
  assign op_in[5] = bus.multiplier_5;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = bus.mul_valid ? MUL : IDLE;
      MUL:     state_next = (cnt_reg == 3'd5) ? DONE : MUL;
      DONE:    state_next = bus.res_ready ? IDLE : DONE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy_c      = 1'b0;
    res_valid_c = 1'b0;
    case (state_reg)
      MUL:     busy_c = 1'b1;
      DONE: begin
        busy_c      = 1'b1;
        res_valid_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur_op = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (cnt_reg == 3'(i)) cur_op = op_reg[i];
    end
  end

  assign product = {{OP_W{1'b0}}, acc_reg} * {{OP_W{1'b0}}, cur_op};
  assign sat_hit = |(product >> (OP_W + FRAC_W));

  // A zero operand marks an unused slot; once saturated the accumulator is pinned at full scale
  always_comb begin
    acc_step = acc_reg;
    sat_step = 1'b0;
    if (cur_op != '0) begin
      if (ovf_reg || sat_hit) begin
        acc_step = '1;
        sat_step = 1'b1;
      end else begin
        acc_step = OP_W'(product >> FRAC_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OPS; i++) op_reg[i] <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      drop_reg   <= 1'b0;
    end else begin
      drop_reg <= bus.mul_valid && ((state_reg == MUL) || (state_reg == DONE));
      case (state_reg)
        IDLE: begin
          if (bus.mul_valid) begin
            for (int i = 0; i < N_OPS; i++) op_reg[i] <= op_in[i];
            acc_reg <= OP_W'(26'd1 << FRAC_W);
            cnt_reg <= '0;
            ovf_reg <= 1'b0;
          end
        end
        MUL: begin
          acc_reg    <= acc_step;
          result_reg <= acc_step;
          ovf_reg    <= ovf_reg | sat_step;
          cnt_reg    <= cnt_reg + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.res_valid = res_valid_c;
  assign bus.result    = result_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.drop      = drop_reg;

endmodule

// File: tb/tb_exp_prod_sched.sv
// Randomized scoreboard bench for exp_prod_sched: a driver issues operand sets and pushes
// reference products; an independent monitor pops and compares on every res_valid cycle.
module tb_exp_prod_sched;

  localparam int FRAC_W = 11;
  localparam logic [25:0] MAXV = 26'h3FFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  exp_prod_sched_if bus();

  exp_prod_sched #(.FRAC_W(FRAC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef logic [5:0][25:0] ops_t;
  typedef struct {
    logic [25:0] res;
    logic        ovf;
    int          e0;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   drop_exp = 0;
  int   drop_seen = 0;
  bit   in_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: running product from 1.0, zero slots skipped, saturation is sticky
  function automatic logic [26:0] model(input ops_t ops);
    longint acc = longint'(1) << FRAC_W;
    longint lim = longint'(1) << (26 + FRAC_W);
    longint p;
    bit sat = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ops[i] == 26'd0 || sat) continue;
      p = acc * longint'(ops[i]);
      if (p >= lim) begin
        sat = 1'b1;
        acc = (longint'(1) << 26) - 1;
      end else begin
        acc = p >> FRAC_W;
      end
    end
    return {sat, 26'(acc)};
  endfunction

  function automatic ops_t all_of(input logic [25:0] v);
    ops_t o;
    for (int i = 0; i < 6; i++) o[i] = v;
    return o;
  endfunction

  function automatic logic [25:0] rand_op();
    int r = $urandom_range(0, 9);
    if (r < 2)  return 26'd0;
    if (r < 8)  return 26'($urandom_range(1024, 4096));
    if (r == 8) return 26'($urandom_range(1, 2047));
    return 26'($urandom);
  endfunction

  task automatic set_ops(input ops_t o);
    bus.multiplier_0 = o[0];
    bus.multiplier_1 = o[1];
    bus.multiplier_2 = o[2];
    bus.multiplier_3 = o[3];
    bus.multiplier_4 = o[4];
    bus.multiplier_5 = o[5];
  endtask

  task automatic scramble_ops();
    ops_t o;
    for (int i = 0; i < 6; i++) o[i] = 26'($urandom);
    set_ops(o);
  endtask

  // Monitor: counts drop pulses and checks every cycle the result is presented
  always @(negedge clk) begin
    if (rst_n && bus.drop) drop_seen++;
    if (rst_n && bus.res_valid) begin
      if (!in_done) begin
        if (sb.size() == 0) begin
          check("unexpected_res_valid", 1, 0);
        end else begin
          cur = sb.pop_front();
          in_done = 1'b1;
          check("latency", cyc - cur.e0, 6);
        end
      end
      if (in_done) begin
        check("result", bus.result, cur.res);
        check("ovf", bus.ovf, cur.ovf);
        check("busy_in_done", bus.busy, 1);
      end
    end else begin
      in_done = 1'b0;
    end
  end

  // Called just after a negedge; returns just after a negedge with the DUT idle
  task automatic run_txn(input ops_t ops, input int hold, input bit rej_mul,
                         input bit rej_done, input bit rej_hs,
                         input int peek_at, input logic [25:0] peek_val);
    logic [26:0] ref_v;
    exp_t e;
    int n;
    ref_v = model(ops);
    e.res = ref_v[25:0];
    e.ovf = ref_v[26];
    e.e0  = cyc + 1;
    set_ops(ops);
    bus.mul_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.mul_valid = 1'b0;
    scramble_ops();
    check("busy_after_e0", bus.busy, 1);
    if (peek_at > 0) begin
      repeat (peek_at) @(negedge clk);
      check("mid_result", bus.result, peek_val);
    end
    if (rej_mul) begin
      bus.mul_valid = 1'b1;
      drop_exp++;
      @(negedge clk);
      bus.mul_valid = 1'b0;
    end
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) check("res_valid_timeout", 0, 1);
    for (int k = 0; k < hold; k++) begin
      bus.mul_valid = (rej_done && k == 0);
      if (rej_done && k == 0) drop_exp++;
      @(negedge clk);
      bus.mul_valid = 1'b0;
    end
    bus.res_ready = 1'b1;
    if (rej_hs) begin
      bus.mul_valid = 1'b1;
      drop_exp++;
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.mul_valid = 1'b0;
    check("res_valid_after_hs", bus.res_valid, 0);
    check("busy_after_hs", bus.busy, 0);
    @(negedge clk);
    #1;
    check("drop_count", drop_seen, drop_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ops_t o;
    bus.mul_valid = 1'b0;
    bus.res_ready = 1'b0;
    set_ops(all_of(26'd0));

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_drop", bus.drop, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(all_of(26'd2048), 0, 1'b0, 1'b0, 1'b0, 0, 26'd0);
    run_txn(all_of(26'd4096), 2, 1'b0, 1'b0, 1'b0, 0, 26'd0);
    run_txn(all_of(26'd3072), 1, 1'b0, 1'b0, 1'b0, 2, 26'd4608);
    o = all_of(26'd0);
    o[0] = 26'd5567;
    run_txn(o, 0, 1'b0, 1'b0, 1'b0, 0, 26'd0);
    run_txn(all_of(MAXV), 3, 1'b0, 1'b0, 1'b0, 0, 26'd0);
    check("ovf_held_idle", bus.ovf, 1);
    check("result_held_idle", bus.result, MAXV);
    run_txn(all_of(26'd2048), 10, 1'b1, 1'b1, 1'b1, 0, 26'd0);

    // Abandon a computation mid-flight with an asynchronous reset at cnt=3
    set_ops(all_of(26'd3000));
    bus.mul_valid = 1'b1;
    @(negedge clk);
    bus.mul_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_ovf", bus.ovf, 0);
    check("midrst_res_valid", bus.res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_idle", bus.busy, 0);
    run_txn(all_of(26'd3072), 0, 1'b0, 1'b0, 1'b0, 0, 26'd0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 6; i++) o[i] = rand_op();
      run_txn(o, $urandom_range(0, 12), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 26'd0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("drop_total", drop_seen, drop_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
